// File: rtl/mdu_pkg.sv
// Shared encodings and latencies for the multiply/divide unit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB operations.
package mdu_pkg;

    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 10;
    localparam int CNT_W      = 4;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MADD  = 4'd6,
        MD_MADDU = 4'd7,
        MD_MSUB  = 4'd8
    } mdop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    // Multiply-latency operations; the accumulate variants exist only when built in.
    function automatic logic is_mul_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit quotient/remainder, signed or unsigned.
// Signed results truncate toward zero; the remainder takes the dividend's sign.
module mdu_div
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b, uquo, urem;

    // Working on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    always_comb begin
        neg_a = signed_i & a_i[31];
        neg_b = signed_i & b_i[31];
        abs_a = neg_a ? (~a_i + 32'd1) : a_i;
        abs_b = neg_b ? (~b_i + 32'd1) : b_i;
        uquo  = '0;
        urem  = '0;
        if (abs_b != 32'd0) begin
            uquo = abs_a / abs_b;
            urem = abs_a % abs_b;
        end
        quo_o = (neg_a ^ neg_b) ? (~uquo + 32'd1) : uquo;
        rem_o = neg_a ? (~urem + 32'd1) : urem;
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a down-counting latency timer.
// Define MDU_MADD_EN to build in MADD/MADDU/MSUB accumulate operations.
//
// state | meaning
// IDLE  | accepts start (mul/div) or we (MTHI/MTLO)
// MUL   | multiply in flight, HI/LO written when counter reaches 1
// DIV   | divide in flight, HI/LO written when counter reaches 1 unless B == 0
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [3:0]  MDop,
    input  logic        start,
    input  logic        we,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, b_q, hi_q, lo_q, hi_d, lo_d;
    logic [3:0]         op_q;
    logic [63:0]        prod_s, prod_u, mul_res;
    logic [31:0]        quo, rem;
    logic               accept_mul, accept_div, done;

    assign accept_mul = (state_q == IDLE) && start && is_mul_op(MDop);
    assign accept_div = (state_q == IDLE) && start && is_div_op(MDop);
    assign done       = (state_q != IDLE) && (cnt_q == CNT_W'(1));

    mdu_div u_div (
        .a_i      (a_q),
        .b_i      (b_q),
        .signed_i (op_q == MD_DIV),
        .quo_o    (quo),
        .rem_o    (rem)
    );

    always_comb begin
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        mul_res = prod_s;
        case (op_q)
            MD_MULTU: mul_res = prod_u;
`ifdef MDU_MADD_EN
            MD_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            MD_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            MD_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
`endif
            default:  mul_res = prod_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept_mul || accept_div) begin
                a_q  <= D1;
                b_q  <= D2;
                op_q <= MDop;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_mul) begin
                    state_d = MUL;
                    cnt_d   = CNT_W'(MUL_CYCLES);
                end else if (accept_div) begin
                    state_d = DIV;
                    cnt_d   = CNT_W'(DIV_CYCLES);
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (done) state_d = IDLE;
            end
        endcase
    end

    // start always wins over we in the same cycle, whatever MDop is.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: begin
                if (we && !start) begin
                    if (MDop == MD_MTHI) hi_d = D1;
                    if (MDop == MD_MTLO) lo_d = D1;
                end
            end
            MUL: begin
                if (done) {hi_d, lo_d} = mul_res;
            end
            DIV: begin
                if (done && (b_q != 32'd0)) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed vector bench for mdu: table of single operations plus hand-written
// sequences for reset, ignored strobes while busy, and start/we collisions.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] D1 = '0, D2 = '0;
    logic [3:0]  MDop = 4'hF;
    logic        start = 1'b0, we = 1'b0;
    logic        busy;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .D1      (D1),
        .D2      (D2),
        .MDop    (MDop),
        .start   (start),
        .we      (we),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); we = 1'b1; MDop = MD_MTHI; D1 = h;
        @(negedge clk); MDop = MD_MTLO; D1 = l;
        @(negedge clk); we = 1'b0; MDop = 4'hF;
    endtask

    // Launch one op, scramble inputs afterwards, count busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk); start = 1'b1; MDop = op; D1 = a; D2 = b;
        @(negedge clk); start = 1'b0; MDop = 4'hF; D1 = 32'hDEADBEEF; D2 = 32'd0;
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;

        vecs.push_back('{"mult_neg2x3",   MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        vecs.push_back('{"multu_max",     MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5});
        vecs.push_back('{"mult_extreme",  MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'hC0000000, 32'h80000000, 5});
        vecs.push_back('{"div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{"div_7_m2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10});
        vecs.push_back('{"divu_7_2",      MD_DIVU,  32'd7,        32'd2,        32'h0, 32'h0, 32'h00000001, 32'h00000003, 10});
        vecs.push_back('{"divu_max_2",    MD_DIVU,  32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFF, 10});
        vecs.push_back('{"div_ovf",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 10});
        vecs.push_back('{"divu_by_zero",  MD_DIVU,  32'd7,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10});
        vecs.push_back('{"div_by_zero",   MD_DIV,   32'd5,        32'd0,        32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10});
        vecs.push_back('{"bad_op",        4'hF,     32'd3,        32'd3,        32'h1, 32'h2, 32'h00000001, 32'h00000002, 0});
        vecs.push_back('{"start_mthi",    MD_MTHI,  32'h99,       32'd3,        32'h3, 32'h4, 32'h00000003, 32'h00000004, 0});
`ifdef MDU_MADD_EN
        vecs.push_back('{"maddu_carry",   MD_MADDU, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5});
        vecs.push_back('{"madd_neg",      MD_MADD,  32'hFFFFFFFF, 32'd2,        32'h0, 32'h5, 32'h00000000, 32'h00000003, 5});
        vecs.push_back('{"msub_1x1",      MD_MSUB,  32'd1,        32'd1,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5});
`else
        vecs.push_back('{"maddu_off",     MD_MADDU, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0});
        vecs.push_back('{"msub_off",      MD_MSUB,  32'd1,        32'd1,        32'h7, 32'h8, 32'h00000007, 32'h00000008, 0});
`endif

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
            check({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
        end

        // Second start and an MTLO while a MULTU runs are both ignored.
        preload(32'h1, 32'h2);
        @(negedge clk); start = 1'b1; MDop = MD_MULTU; D1 = 32'h10; D2 = 32'h10;
        @(negedge clk); start = 1'b0; MDop = 4'hF;
        @(negedge clk); start = 1'b1; MDop = MD_MULT; D1 = 32'd3; D2 = 32'd3;
        @(negedge clk); start = 1'b0; we = 1'b1; MDop = MD_MTLO; D1 = 32'h55;
        @(negedge clk); we = 1'b0; MDop = 4'hF;
        cyc = 3;
        while (busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_ign_cycles", cyc, 5);
        check("busy_ign_hi", HI, 32'h0);
        check("busy_ign_lo", LO, 32'h100);

        // Reset mid-divide, then a MULT launched on the first edge after release.
        preload(32'h12, 32'h34);
        @(negedge clk); start = 1'b1; MDop = MD_DIV; D1 = 32'd100; D2 = 32'd7;
        @(negedge clk); start = 1'b0; MDop = 4'hF;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        #1 reset_n = 1'b1;
        start = 1'b1; MDop = MD_MULT; D1 = 32'd2; D2 = 32'd3;
        @(negedge clk); start = 1'b0; MDop = 4'hF;
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        check("post_rst_cycles", cyc, 5);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd6);

        // start and we together with a multiply op: multiply runs, nothing else written.
        @(negedge clk); start = 1'b1; we = 1'b1; MDop = MD_MULTU; D1 = 32'd4; D2 = 32'd5;
        @(negedge clk); start = 1'b0; we = 1'b0; MDop = 4'hF;
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        check("start_we_cycles", cyc, 5);
        check("start_we_lo", LO, 32'd20);

        // MTHI alone in IDLE writes HI from D1 without touching LO.
        @(negedge clk); we = 1'b1; MDop = MD_MTHI; D1 = 32'hCAFEF00D;
        @(negedge clk); we = 1'b0; MDop = 4'hF;
        check("mthi_hi", HI, 32'hCAFEF00D);
        check("mthi_lo", LO, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
